// File: rtl/scancode_arb_pkg.sv
// Shared types and constants for the scancode arbiter and its strobe generator.
package scancode_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_REL   = 8'hF0;
  localparam logic [7:0] SC_FLUSH = 8'h00;

  localparam logic SRC_KB  = 1'b0;
  localparam logic SRC_INJ = 1'b1;

  // A prefix byte keeps the owning source locked until its final byte.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_REL);
  endfunction

endpackage

// File: rtl/scan_strobe_gen.sv
// Sequences one SETUP / PULSE / GAP strobe per start; powers up mid-sequence
// so the first strobe after reset is the decoder flush.
module scan_strobe_gen
  import scancode_arb_pkg::*;
#(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_strobe,
  output logic o_idle,
  output logic o_done
);

  localparam int unsigned MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_strobe;
  logic             w_strobe_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SETUP;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_next;
      r_strobe <= w_strobe_d;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next     = SETUP;
          w_cnt_next = '0;
        end
      end
      SETUP: begin
        w_next     = PULSE;
        w_cnt_next = '0;
      end
      PULSE: begin
        if (r_cnt == PULSE_LAST) begin
          w_next     = GAP;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_next     = IDLE;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // Strobe is registered from the next state so it is glitch-free at the pin.
  always_comb begin
    w_strobe_d = (w_next == PULSE);
    o_idle     = (r_state == IDLE);
    o_done     = (r_state == GAP) && (r_cnt == GAP_LAST);
  end

  assign o_strobe = r_strobe;

endmodule

// File: rtl/scancode_arbiter.sv
// Shares the scancode decoder between the keyboard receiver and the injector,
// keeping prefixed sequences atomic and flushing the decoder after stalls.
module scancode_arbiter
  import scancode_arb_pkg::*;
#(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kb_valid,
  input  logic [7:0] kb_data,
  output logic       kb_ready,
  input  logic       inj_valid,
  input  logic [7:0] inj_data,
  output logic       inj_ready,
  output logic [7:0] scan,
  output logic       scan_received,
  output logic       owner,
  output logic       locked,
  output logic       timeout_pulse
);

  localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;
  localparam bit          TMO_EN   = (TIMEOUT != 16'd0);

  logic [7:0]  r_scan;
  logic        r_owner;
  logic        r_locked;
  logic        r_tmo_pulse;
  logic [15:0] r_tmo_cnt;
  logic        r_flush;
  logic        r_first;

  logic       w_idle;
  logic       w_done;
  logic       w_strobe;
  logic       w_can_grant;
  logic       w_pref;
  logic       w_gnt;
  logic       w_accept;
  logic       w_acc_src;
  logic [7:0] w_acc_data;
  logic       w_tmo_hit;
  logic       w_start;

  scan_strobe_gen #(
    .PULSE_W (PULSE_W),
    .GAP_W   (GAP_W)
  ) u_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .o_strobe (w_strobe),
    .o_idle   (w_idle),
    .o_done   (w_done)
  );

  // Grant: lock pins the owner; otherwise the source that went last yields.
  always_comb begin
    w_can_grant = w_idle && !r_flush;
    w_pref      = r_first ? SRC_KB : ~r_owner;
    if (w_pref == SRC_KB) begin
      w_gnt = (kb_valid || !inj_valid) ? SRC_KB : SRC_INJ;
    end else begin
      w_gnt = (inj_valid || !kb_valid) ? SRC_INJ : SRC_KB;
    end
    if (r_locked) begin
      w_gnt = r_owner;
    end
    kb_ready   = w_can_grant && kb_valid  && (w_gnt == SRC_KB);
    inj_ready  = w_can_grant && inj_valid && (w_gnt == SRC_INJ);
    w_accept   = kb_ready || inj_ready;
    w_acc_src  = inj_ready ? SRC_INJ : SRC_KB;
    w_acc_data = inj_ready ? inj_data : kb_data;
    w_tmo_hit  = TMO_EN && w_idle && r_locked && !w_accept && (r_tmo_cnt == TMO_LAST);
    w_start    = w_accept || w_tmo_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan      <= SC_FLUSH;
      r_owner     <= SRC_KB;
      r_locked    <= 1'b0;
      r_tmo_pulse <= 1'b0;
      r_tmo_cnt   <= '0;
      r_flush     <= 1'b1;
      r_first     <= 1'b1;
    end else begin
      r_tmo_pulse <= w_tmo_hit;
      if (w_accept) begin
        r_scan   <= w_acc_data;
        r_owner  <= w_acc_src;
        r_locked <= is_prefix(w_acc_data);
        r_first  <= 1'b0;
      end else if (w_tmo_hit) begin
        r_scan   <= SC_FLUSH;
        r_locked <= 1'b0;
      end
      // Flush flag blocks grants until the flush strobe has completed.
      if (w_tmo_hit) begin
        r_flush <= 1'b1;
      end else if (w_done) begin
        r_flush <= 1'b0;
      end
      if (!w_idle || !r_locked || w_accept) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
    end
  end

  assign scan          = r_scan;
  assign scan_received = w_strobe;
  assign owner         = r_owner;
  assign locked        = r_locked;
  assign timeout_pulse = r_tmo_pulse;

endmodule

// File: tb/tb_scancode_arbiter.sv
// Self-checking bench: vector table, corner-case sequences and a randomized
// run against a transaction-level model of the arbiter.
module tb_scancode_arbiter;

  localparam int TMO = 100;

  logic       clk;
  logic       rst_n;
  logic       kb_valid;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       inj_valid;
  logic [7:0] inj_data;
  logic       inj_ready;
  logic [7:0] scan;
  logic       scan_received;
  logic       owner;
  logic       locked;
  logic       timeout_pulse;

  int n_chk = 0;
  int n_err = 0;

  scancode_arbiter #(
    .PULSE_W (4),
    .GAP_W   (4),
    .TIMEOUT (16'(TMO))
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .kb_valid      (kb_valid),
    .kb_data       (kb_data),
    .kb_ready      (kb_ready),
    .inj_valid     (inj_valid),
    .inj_data      (inj_data),
    .inj_ready     (inj_ready),
    .scan          (scan),
    .scan_received (scan_received),
    .owner         (owner),
    .locked        (locked),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       kv;
    logic [7:0] kd;
    logic       iv;
    logic [7:0] id;
    logic       src;
    logic       lck;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string nm);
    chk({nm, "_scan"},    32'(scan),          32'h00);
    chk({nm, "_strobe"},  32'(scan_received), 32'd0);
    chk({nm, "_kb_rdy"},  32'(kb_ready),      32'd0);
    chk({nm, "_inj_rdy"}, 32'(inj_ready),     32'd0);
    chk({nm, "_owner"},   32'(owner),         32'd0);
    chk({nm, "_locked"},  32'(locked),        32'd0);
    chk({nm, "_tpulse"},  32'(timeout_pulse), 32'd0);
  endtask

  // Starts at the cycle right after a byte (or flush) is taken; ends in IDLE.
  task automatic strobe_seq(input logic [7:0] exp_scan, input string nm);
    int bad;
    bad = 0;
    for (int k = 1; k <= 9; k++) begin
      chk({nm, "_strobe"}, 32'(scan_received), 32'(k >= 2 && k <= 5));
      chk({nm, "_scan"}, 32'(scan), 32'(exp_scan));
      if (kb_ready || inj_ready || (k > 1 && timeout_pulse)) bad++;
      tick();
    end
    chk({nm, "_busy_quiet"}, 32'(bad), 32'd0);
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #1;
    reset_check(nm);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic xfer(input logic kv, input logic [7:0] kd, input logic iv, input logic [7:0] id,
                      input logic src, input logic lck, input string nm);
    logic [7:0] d;
    d = src ? id : kd;
    kb_valid = kv; kb_data = kd; inj_valid = iv; inj_data = id;
    #1;
    chk({nm, "_kb_rdy"},  32'(kb_ready),  32'(kv && src == 1'b0));
    chk({nm, "_inj_rdy"}, 32'(inj_ready), 32'(iv && src == 1'b1));
    tick();
    if (src) inj_valid = 1'b0; else kb_valid = 1'b0;
    chk({nm, "_owner"},  32'(owner),         32'(src));
    chk({nm, "_locked"}, 32'(locked),        32'(lck));
    chk({nm, "_tpulse"}, 32'(timeout_pulse), 32'd0);
    strobe_seq(d, nm);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 3))
      0:       return 8'hE0;
      1:       return 8'hF0;
      default: return 8'($urandom_range(1, 127));
    endcase
  endfunction

  vec_t tbl[8];

  // Transaction-level reference state for the randomized run.
  int         m_busy;
  int         m_idle;
  logic       m_owner, m_locked, m_first, m_tp;
  logic [7:0] exp_q[$];

  initial begin
    int   bad;
    logic prev_sr, pref, g, e_kb, e_inj, idle, acc_kb, acc_inj;
    logic [1:0] vv;
    logic [7:0] d;

    tbl[0] = '{1'b1, 8'h1C, 1'b1, 8'h32, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h1D, 1'b1, 8'h32, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h1D, 1'b1, 8'h33, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 8'hE0, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 8'h23, 1'b1, 8'h75, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'hF0, 1'b1, 8'h12, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'h44, 1'b1, 8'h12, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b0};

    rst_n = 1'b0; kb_valid = 1'b0; kb_data = 8'h00; inj_valid = 1'b0; inj_data = 8'h00;

    // Power-up flush, then nobody is readied without a request
    do_reset("por");
    strobe_seq(8'h00, "por_flush");
    chk("por_idle_kb_rdy",  32'(kb_ready),  32'd0);
    chk("por_idle_inj_rdy", 32'(inj_ready), 32'd0);

    for (int r = 0; r < 8; r++) begin
      xfer(tbl[r].kv, tbl[r].kd, tbl[r].iv, tbl[r].id, tbl[r].src, tbl[r].lck,
           $sformatf("vec%0d", r));
    end
    kb_valid = 1'b0; inj_valid = 1'b0;

    // kb E0 F0 75 keeps injector out until the final byte
    xfer(1'b1, 8'hE0, 1'b0, 8'h11, 1'b0, 1'b1, "lock_e0");
    xfer(1'b1, 8'hF0, 1'b1, 8'h11, 1'b0, 1'b1, "lock_f0");
    xfer(1'b1, 8'h75, 1'b1, 8'h11, 1'b0, 1'b0, "lock_75");
    xfer(1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0, "lock_inj");

    // Stalled kb sequence times out and is flushed
    xfer(1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b1, "tmo_f0");
    inj_valid = 1'b1; inj_data = 8'h22;
    #1;
    bad = 0;
    for (int i = 0; i < TMO; i++) begin
      if (inj_ready || kb_ready || timeout_pulse) bad++;
      tick();
    end
    chk("tmo_wait_quiet", 32'(bad), 32'd0);
    chk("tmo_pulse",  32'(timeout_pulse), 32'd1);
    chk("tmo_locked", 32'(locked),        32'd0);
    chk("tmo_owner",  32'(owner),         32'd0);
    strobe_seq(8'h00, "tmo_flush");
    xfer(1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b0, "tmo_inj");

    // Owner byte arriving on the last idle cycle beats the timeout
    xfer(1'b0, 8'h00, 1'b1, 8'hE0, 1'b1, 1'b1, "aw_e0");
    bad = 0;
    for (int i = 0; i < TMO - 1; i++) begin
      if (timeout_pulse) bad++;
      tick();
    end
    chk("aw_wait_quiet", 32'(bad), 32'd0);
    xfer(1'b0, 8'h00, 1'b1, 8'h71, 1'b1, 1'b0, "aw_71");

    // Reset during the pulse of 2A truncates the strobe
    kb_valid = 1'b1; kb_data = 8'h2A;
    #1;
    chk("mid_kb_rdy", 32'(kb_ready), 32'd1);
    tick();
    kb_valid = 1'b0;
    tick();
    tick();
    chk("mid_strobe_hi", 32'(scan_received), 32'd1);
    chk("mid_scan",      32'(scan),          32'h2A);
    kb_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    reset_check("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    strobe_seq(8'h00, "mid_flush");
    xfer(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, "post_rst");

    // Randomized run against the model
    kb_valid = 1'b0; inj_valid = 1'b0;
    do_reset("rnd");
    m_busy = 9; m_idle = 0; m_owner = 1'b0; m_locked = 1'b0; m_first = 1'b1; m_tp = 1'b0;
    exp_q = {};
    exp_q.push_back(8'h00);
    prev_sr = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (scan_received && !prev_sr) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra_strobe", 32'd1, 32'd0);
        end else begin
          chk("rnd_scan", 32'(scan), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      prev_sr = scan_received;
      chk("rnd_tpulse", 32'(timeout_pulse), 32'(m_tp));
      chk("rnd_locked", 32'(locked),        32'(m_locked));
      chk("rnd_owner",  32'(owner),         32'(m_owner));

      if (cyc < 2700) begin
        if (!kb_valid && $urandom_range(0, 2) == 0) begin kb_valid = 1'b1; kb_data = pick(); end
        if (!inj_valid && $urandom_range(0, 2) == 0) begin inj_valid = 1'b1; inj_data = pick(); end
      end
      #1;

      idle = (m_busy == 0);
      vv   = {inj_valid, kb_valid};
      pref = m_first ? 1'b0 : !m_owner;
      g    = vv[pref] ? pref : !pref;
      if (m_locked) g = m_owner;
      e_kb  = idle && kb_valid  && (g == 1'b0);
      e_inj = idle && inj_valid && (g == 1'b1);
      chk("rnd_kb_rdy",  32'(kb_ready),  32'(e_kb));
      chk("rnd_inj_rdy", 32'(inj_ready), 32'(e_inj));

      m_tp = 1'b0; acc_kb = 1'b0; acc_inj = 1'b0;
      if (!idle) begin
        m_busy--;
        m_idle = 0;
      end else if (e_kb || e_inj) begin
        d = e_inj ? inj_data : kb_data;
        exp_q.push_back(d);
        m_owner  = e_inj;
        m_locked = (d == 8'hE0) || (d == 8'hF0);
        m_first  = 1'b0;
        m_busy   = 9;
        m_idle   = 0;
        acc_kb   = e_kb;
        acc_inj  = e_inj;
      end else if (m_locked) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_tp     = 1'b1;
          m_locked = 1'b0;
          m_busy   = 9;
          m_idle   = 0;
          exp_q.push_back(8'h00);
        end
      end else begin
        m_idle = 0;
      end
      tick();
      if (acc_kb)  kb_valid  = 1'b0;
      if (acc_inj) inj_valid = 1'b0;
    end
    chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
